gerador_estimulos_comparador: RTL and testbench

GERADOR_ESTIMULOS_COMPARADOR -- requirements
Module: gerador_estimulos_comparador

---
 rtl/gerador_estimulos_comparador_pkg.sv | 14 +
 rtl/gerador_estimulos_comparador_modelo.sv | 14 +
 rtl/gerador_estimulos_comparador.sv | 103 ++++++++++
 tb/tb_gerador_estimulos_comparador.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/gerador_estimulos_comparador_pkg.sv
// Shared definitions for the exhaustive 6-input comparator stimulus generator.
package gerador_estimulos_comparador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 64;
    localparam int CODE_W      = 6;
    localparam int CNT_W       = 7;

endpackage

// File: rtl/gerador_estimulos_comparador_modelo.sv
// Golden model of the comparator under test: equality of the pairs A/D, B/F, C/E.
module modelo_comparador (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic E,
    input  logic F,
    output logic exp
);

    assign exp = (A == D) & (B == F) & (C == E);

endmodule

// File: rtl/gerador_estimulos_comparador.sv
// Walks all 64 input codes through an external comparator, checks FI against the
// reference model and reports mismatch count, lowest failing code and pass.
module gerador_estimulos_comparador
    import gerador_estimulos_comparador_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             FI,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             E,
    output logic             F,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CODE_W-1:0] first_fail_code
);

    localparam int SET_W = 4;

    state_t            state, state_next;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] vec;
    logic [SET_W-1:0]  settle;
    logic [CNT_W-1:0]  mm_next;
    logic              exp_res;
    logic              sample;
    logic              last;
    logic              fail;

    // Outputs only carry the code while running; idle and done present zero.
    assign vec    = (state == RUN) ? code : '0;
    assign {A, B, C, D, E, F} = vec;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    assign sample = (state == RUN) && (settle == SET_W'(SETTLE_CYCLES - 1));
    assign last   = (code == CODE_W'(NUM_VECTORS - 1));
    assign fail   = sample && (FI != exp_res);
    assign mm_next = (fail && (mismatch_count != CNT_W'(NUM_VECTORS))) ?
                     mismatch_count + 1'b1 : mismatch_count;

    modelo_comparador u_modelo (
        .A  (vec[5]),
        .B  (vec[4]),
        .C  (vec[3]),
        .D  (vec[2]),
        .E  (vec[1]),
        .F  (vec[0]),
        .exp(exp_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code            <= '0;
            settle          <= '0;
            mismatch_count  <= '0;
            first_fail_code <= '0;
            pass            <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                code            <= '0;
                settle          <= '0;
                mismatch_count  <= '0;
                first_fail_code <= '0;
                pass            <= 1'b0;
            end
        end else if (state == RUN) begin
            if (sample) begin
                settle         <= '0;
                mismatch_count <= mm_next;
                if (fail && (mismatch_count == '0)) first_fail_code <= code;
                // pass is settled on the final sample so it is valid during DONE.
                if (last) pass <= (mm_next == '0);
                else      code <= code + 1'b1;
            end else begin
                settle <= settle + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gerador_estimulos_comparador.sv
// Directed bench: two instances (settle 1 and 3) driving a behavioural comparator.
module tb_gerador_estimulos_comparador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic       fi1, fi3;
    logic       a1, b1, c1, d1, e1, f1, busy1, done1, pass1;
    logic       a3, b3, c3, d3, e3, f3, busy3, done3, pass3;
    logic [6:0] mm1, mm3;
    logic [5:0] ff1, ff3;
    int         mode = 0;
    int         npass = 0, ntot = 0;

    always #5 clk = ~clk;

    gerador_estimulos_comparador #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .FI(fi1),
        .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1),
        .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_count(mm1), .first_fail_code(ff1));

    gerador_estimulos_comparador #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .FI(fi3),
        .A(a3), .B(b3), .C(c3), .D(d3), .E(e3), .F(f3),
        .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_count(mm3), .first_fail_code(ff3));

    // Comparator under test: 0 correct, 1 stuck-0, 2 stuck-1, 3 wrong pairing.
    function automatic logic cut(input int m, input logic a, b, c, d, e, f);
        case (m)
            0:       return (a ~^ d) & (b ~^ f) & (c ~^ e);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (a ~^ d) & (b ~^ e) & (c ~^ f);
        endcase
    endfunction

    always_comb fi1 = cut(mode, a1, b1, c1, d1, e1, f1);
    always_comb fi3 = cut(0, a3, b3, c3, d3, e3, f3);

    task automatic check(input string name, input int act, input int req);
        ntot++;
        if (act == req) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Start dut1 and count edges until done; 0 means the bound expired.
    task automatic run1(output int cycles);
        @(negedge clk) start1 = 1'b1;
        @(posedge clk) #1 start1 = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk) #1;
            if (done1) begin cycles = i; break; end
        end
    endtask

    typedef struct {
        int         m;
        int         cycles;
        logic [6:0] mm;
        logic [5:0] first;
        logic       ok;
    } vec_t;

    vec_t tbl[4];
    int   cyc;
    int   done_seen;

    initial begin
        tbl[0] = '{0, 64, 7'd0,  6'd0, 1'b1};
        tbl[1] = '{1, 64, 7'd8,  6'd0, 1'b0};
        tbl[2] = '{2, 64, 7'd56, 6'd1, 1'b0};
        tbl[3] = '{3, 64, 7'd8,  6'd9, 1'b0};

        #1;
        check("reset_outputs1", {a1,b1,c1,d1,e1,f1,busy1,done1,pass1,mm1,ff1}, 0);
        check("reset_outputs3", {a3,b3,c3,d3,e3,f3,busy3,done3,pass3,mm3,ff3}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_busy", {busy1, done1}, 0);

        // First vectors appear on the outputs right after the start edge.
        mode = 0;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk) #1 start1 = 1'b0;
        check("run_busy", busy1, 1);
        check("vec0", {a1,b1,c1,d1,e1,f1}, 0);
        @(posedge clk) #1;
        check("vec1", {a1,b1,c1,d1,e1,f1}, 1);
        @(posedge clk) #1;
        check("vec2", {a1,b1,c1,d1,e1,f1}, 2);
        for (int i = 0; i < 70 && !done1; i++) @(posedge clk) #1;
        @(posedge clk) #1;

        for (int t = 0; t < 4; t++) begin
            mode = tbl[t].m;
            run1(cyc);
            check($sformatf("cycles_m%0d", t), cyc, tbl[t].cycles);
            check($sformatf("busy_in_done_m%0d", t), busy1, 0);
            check($sformatf("mm_m%0d", t), mm1, tbl[t].mm);
            check($sformatf("pass_m%0d", t), pass1, tbl[t].ok);
            if (tbl[t].mm != 0) check($sformatf("first_m%0d", t), ff1, tbl[t].first);
            @(posedge clk) #1;
            check($sformatf("done_pulse_m%0d", t), done1, 0);
            check($sformatf("idle_vec_m%0d", t), {a1,b1,c1,d1,e1,f1,busy1}, 0);
            check($sformatf("hold_mm_m%0d", t), mm1, tbl[t].mm);
            check($sformatf("hold_pass_m%0d", t), pass1, tbl[t].ok);
        end

        // Start ignored while in IDLE hold: results stay until next accepted start.
        repeat (3) @(posedge clk);
        #1 check("hold_after_idle", mm1, 8);

        // Reset mid-run aborts without done.
        mode = 1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk) #1 start1 = 1'b0;
        repeat (19) @(posedge clk);
        #1 check("mm_before_abort_nonzero", (mm1 != 0), 1);
        @(negedge clk) rst_n = 1'b0;
        #1 check("abort_outputs", {a1,b1,c1,d1,e1,f1,busy1,done1,pass1,mm1,ff1}, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk) #1;
            if (done1) done_seen++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1;
            if (done1 || busy1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        mode = 0;
        run1(cyc);
        check("rerun_cycles", cyc, 64);
        check("rerun_pass", pass1, 1);
        check("rerun_mm", mm1, 0);

        // Settle 3 with a repeated start at cycle 30.
        @(negedge clk) start3 = 1'b1;
        @(posedge clk) #1 start3 = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            if (i == 30) begin
                @(negedge clk) start3 = 1'b1;
                @(posedge clk) #1 start3 = 1'b0;
            end else begin
                @(posedge clk) #1;
            end
            if (i == 4) check("s3_vec_hold", {a3,b3,c3,d3,e3,f3}, 1);
            if (done3) begin cyc = i; break; end
        end
        check("s3_cycles", cyc, 192);
        check("s3_pass", pass3, 1);
        check("s3_mm", mm3, 0);
        @(posedge clk) #1;
        check("s3_done_pulse", {done3, busy3}, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
